baud_tick_gen: RTL and testbench

Parametrised, runtime-programmable baud tick generator for the UART. It produces a one-cycle oversample strobe `rx_en` for the receiver and a one-cycle bit strobe `tx_en` for the transmitter. Both are derived from a single integer-plus-fractional divider, so the two strobes stay phase-locked. The divisor can be changed glitch-free at run time through a load/acknowledge handshake, with the change applied only on a bit boundary.

---
 rtl/baud_tick_gen_if.sv | 45 ++++
 rtl/baud_tick_gen.sv | 184 ++++++++++++++++++
 tb/tb_baud_tick_gen.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_if.sv
// -----------------------------------------------------------------------------
// baud_tick_gen_if
//
// Control/strobe bundle between a UART and its baud tick generator.
//
//   en        master->slave  generator enable
//   div_int   master->slave  requested integer divisor   [DIV_WIDTH-1:0]
//   div_frac  master->slave  requested fractional divisor [FRAC_WIDTH-1:0]
//   div_load  master->slave  one-cycle request to capture div_int/div_frac
//   div_ack   slave->master  one-cycle pulse when the captured divisor is live
//   rx_en     slave->master  oversample strobe
//   tx_en     slave->master  bit strobe (coincident with every OVERSAMPLE-th rx_en)
// -----------------------------------------------------------------------------
interface baud_tick_gen_if #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4
);
  logic                  en;
  logic [DIV_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  div_load;
  logic                  div_ack;
  logic                  rx_en;
  logic                  tx_en;

  modport master (
    output en,
    output div_int,
    output div_frac,
    output div_load,
    input  div_ack,
    input  rx_en,
    input  tx_en
  );

  modport slave (
    input  en,
    input  div_int,
    input  div_frac,
    input  div_load,
    output div_ack,
    output rx_en,
    output tx_en
  );
endinterface

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//
// Runtime-programmable baud tick generator. A single integer-plus-fractional
// divider produces the receiver oversample strobe (rx_en); every OVERSAMPLE-th
// rx_en is also a transmitter bit strobe (tx_en), so both stay phase-locked.
//
// The divisor is changed through a load/ack handshake. A load is held pending
// and only becomes active on a bit boundary (tx_en) while running, or on the
// next clock while disabled, so a divisor change never produces a runt bit.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    baud_tick_gen_if.slave: en, div_int, div_frac, div_load in;
//          div_ack, rx_en, tx_en out (all outputs registered)
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int unsigned DIV_WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH       = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 325,
  parameter int unsigned DEFAULT_DIV_FRAC = 8
) (
  input  logic           clk,
  input  logic           reset,
  baud_tick_gen_if.slave bus
);

  localparam int unsigned           OS_WIDTH = $clog2(OVERSAMPLE);
  localparam logic [OS_WIDTH-1:0]   OS_LAST  = OS_WIDTH'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0]  MIN_DIV  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0]  DEF_INT  = DIV_WIDTH'(DEFAULT_DIV_INT);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = FRAC_WIDTH'(DEFAULT_DIV_FRAC);

  // Phase state
  logic [DIV_WIDTH-1:0]  cnt_q,       cnt_d;
  logic [OS_WIDTH-1:0]   os_cnt_q,    os_cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q,       acc_d;
  logic                  ext_q,       ext_d;

  // Active and pending divisors
  logic [DIV_WIDTH-1:0]  act_int_q,   act_int_d;
  logic [FRAC_WIDTH-1:0] act_frac_q,  act_frac_d;
  logic                  pend_q,      pend_d;
  logic [DIV_WIDTH-1:0]  pend_int_q,  pend_int_d;
  logic [FRAC_WIDTH-1:0] pend_frac_q, pend_frac_d;

  // Registered outputs
  logic                  rx_en_q,     rx_en_d;
  logic                  tx_en_q,     tx_en_d;
  logic                  div_ack_q,   div_ack_d;

  // Derived period terms
  logic [DIV_WIDTH-1:0]  eff_int;
  logic [DIV_WIDTH:0]    period_last;
  logic                  period_wrap;
  logic                  os_wrap;
  logic [FRAC_WIDTH:0]   acc_sum;

  always_comb begin
    // Divisors of 0 and 1 cannot produce a one-cycle-wide strobe with a
    // low phase, so they run as 2.
    eff_int = (act_int_q < MIN_DIV) ? MIN_DIV : act_int_q;

    // One bit wider than the counter: I = 2^DIV_WIDTH-1 plus the extra
    // fractional cycle must not wrap the terminal-count value.
    period_last = {1'b0, eff_int}
                + {{DIV_WIDTH{1'b0}}, ext_q}
                - {{DIV_WIDTH{1'b0}}, 1'b1};
    period_wrap = ({1'b0, cnt_q} == period_last);
    os_wrap     = (os_cnt_q == OS_LAST);
    acc_sum     = {1'b0, acc_q} + {1'b0, act_frac_q};
  end

  always_comb begin
    cnt_d       = cnt_q;
    os_cnt_d    = os_cnt_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    rx_en_d     = 1'b0;
    tx_en_d     = 1'b0;
    div_ack_d   = 1'b0;

    if (!bus.en) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      acc_d    = '0;
      ext_d    = 1'b0;

      // While idle there is no bit boundary to wait for. An older pending
      // value goes live first (and a simultaneous load becomes the new
      // pending value); otherwise a fresh load goes live on the edge that
      // captures it, so div_ack follows div_load by one cycle.
      if (pend_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
        div_ack_d  = 1'b1;
        pend_d     = 1'b0;
        if (bus.div_load) begin
          pend_d      = 1'b1;
          pend_int_d  = bus.div_int;
          pend_frac_d = bus.div_frac;
        end
      end else if (bus.div_load) begin
        act_int_d  = bus.div_int;
        act_frac_d = bus.div_frac;
        div_ack_d  = 1'b1;
      end
    end else begin
      if (period_wrap) begin
        cnt_d    = '0;
        rx_en_d  = 1'b1;
        os_cnt_d = os_wrap ? '0 : os_cnt_q + 1'b1;
        acc_d    = acc_sum[FRAC_WIDTH-1:0];
        ext_d    = acc_sum[FRAC_WIDTH];

        if (os_wrap) begin
          tx_en_d = 1'b1;
          // Bit boundary: switch divisor and restart the fractional phase
          // so the next period is exactly the new I.
          if (pend_q) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            acc_d      = '0;
            ext_d      = 1'b0;
            pend_d     = 1'b0;
            div_ack_d  = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Evaluated after the apply so a coincident load survives as the
      // next pending value.
      if (bus.div_load) begin
        pend_d      = 1'b1;
        pend_int_d  = bus.div_int;
        pend_frac_d = bus.div_frac;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      os_cnt_q    <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
      act_int_q   <= DEF_INT;
      act_frac_q  <= DEF_FRAC;
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      rx_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      div_ack_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      os_cnt_q    <= os_cnt_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      rx_en_q     <= rx_en_d;
      tx_en_q     <= tx_en_d;
      div_ack_q   <= div_ack_d;
    end
  end

  assign bus.rx_en   = rx_en_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.div_ack = div_ack_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;
  localparam int unsigned DW     = 16;
  localparam int unsigned FW     = 4;
  localparam int unsigned OS     = 16;
  localparam int unsigned DEF_I  = 325;
  localparam int unsigned DEF_F  = 8;
  localparam int unsigned FRAC_N = 1 << FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  baud_tick_gen_if #(.DIV_WIDTH(DW), .FRAC_WIDTH(FW)) bus ();

  baud_tick_gen #(
    .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS),
    .DEFAULT_DIV_INT(DEF_I), .DEFAULT_DIV_FRAC(DEF_F)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  // Reference model: rx pulse k (k>=1) of a phase segment is high in the
  // cycle after enabled edge k*I + floor((k-1)*F/2^FW) counted from the
  // segment start; every OS-th pulse is a bit strobe.
  int unsigned m_int, m_frac, m_pint, m_pfrac, m_e, m_k, m_next;
  bit m_pend, exp_rx, exp_tx, exp_ack;

  function automatic int unsigned pulse_edge(int unsigned k, int unsigned i_raw, int unsigned f);
    int unsigned i;
    i = (i_raw < 2) ? 2 : i_raw;
    return k * i + ((k - 1) * f) / FRAC_N;
  endfunction

  function automatic void model_restart();
    m_e = 0;
    m_k = 1;
    m_next = pulse_edge(1, m_int, m_frac);
  endfunction

  function automatic void model_step();
    bit had;
    exp_rx = 0; exp_tx = 0; exp_ack = 0;
    if (rst) begin
      m_int = DEF_I; m_frac = DEF_F; m_pend = 0;
      model_restart();
    end else if (!bus.en) begin
      had = m_pend;
      if (had) begin
        m_int = m_pint; m_frac = m_pfrac; m_pend = 0; exp_ack = 1;
      end else if (bus.div_load) begin
        m_int = 32'(bus.div_int); m_frac = 32'(bus.div_frac); exp_ack = 1;
      end
      if (had && bus.div_load) begin
        m_pend = 1; m_pint = 32'(bus.div_int); m_pfrac = 32'(bus.div_frac);
      end
      model_restart();
    end else begin
      m_e++;
      if (m_e == m_next) begin
        exp_rx = 1;
        exp_tx = (m_k % OS) == 0;
        if (exp_tx && m_pend) begin
          m_int = m_pint; m_frac = m_pfrac; m_pend = 0; exp_ack = 1;
          model_restart();
        end else begin
          m_k++;
          m_next = pulse_edge(m_k, m_int, m_frac);
        end
      end
      if (bus.div_load) begin
        m_pend = 1; m_pint = 32'(bus.div_int); m_pfrac = 32'(bus.div_frac);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int unsigned last_rx, last_tx, sp, n326;
    bit seen_rx, seen_tx;
    int unsigned win[$];
    rst = 1'b1; bus.en = 1'b1; bus.div_load = 1'b1;
    bus.div_int = 16'($urandom); bus.div_frac = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got rx/tx/ack=%b%b%b want 000", cyc, bus.rx_en, bus.tx_en, bus.div_ack);
      end
    end
    rst = 1'b0; bus.div_load = 1'b0;
    seen_rx = 0; seen_tx = 0; last_rx = 0; last_tx = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL default_run cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (bus.rx_en === 1'b1) begin
        if (seen_rx) begin
          sp = cyc - last_rx;
          n_vec++;
          if (sp != 325 && sp != 326) begin
            n_err++;
            $display("FAIL default_rx_spacing cyc=%0d got %0d want 325 or 326", cyc, sp);
          end
          win.push_back(sp);
          if (win.size() > 16) void'(win.pop_front());
          if (win.size() == 16) begin
            n326 = 0;
            foreach (win[j]) if (win[j] == 326) n326++;
            n_vec++;
            if (n326 != 8) begin
              n_err++;
              $display("FAIL default_326_count cyc=%0d got %0d want 8", cyc, n326);
            end
          end
        end
        seen_rx = 1; last_rx = cyc;
      end
      if (bus.tx_en === 1'b1) begin
        n_vec++;
        if (bus.rx_en !== 1'b1) begin
          n_err++;
          $display("FAIL tx_with_rx cyc=%0d got rx=%b want 1", cyc, bus.rx_en);
        end
        if (seen_tx) begin
          n_vec++;
          if (cyc - last_tx != 5208) begin
            n_err++;
            $display("FAIL default_tx_spacing cyc=%0d got %0d want 5208", cyc, cyc - last_tx);
          end
        end
        seen_tx = 1; last_tx = cyc;
      end
    end
  endtask

  task automatic test_int_enable_low();
    int unsigned first_rx, last_tx;
    bit seen_tx;
    bus.en = 1'b0; bus.div_load = 1'b0;
    tick();
    bus.div_load = 1'b1; bus.div_int = 16'd4; bus.div_frac = 4'd0;
    tick();
    bus.div_load = 1'b0;
    n_vec++;
    if (bus.div_ack !== 1'b1) begin
      n_err++;
      $display("FAIL int_ack_next_cycle got %b want 1", bus.div_ack);
    end
    tick();
    n_vec++;
    if (bus.div_ack !== 1'b0) begin
      n_err++;
      $display("FAIL int_ack_single got %b want 0", bus.div_ack);
    end
    bus.en = 1'b1;
    first_rx = 0; seen_tx = 0; last_tx = 0;
    for (int i = 1; i <= 3 * 64 + 4; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL int_run cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (bus.rx_en === 1'b1 && first_rx == 0) first_rx = i;
      if (bus.tx_en === 1'b1) begin
        if (seen_tx) begin
          n_vec++;
          if (cyc - last_tx != 64) begin
            n_err++;
            $display("FAIL int_tx_spacing got %0d want 64", cyc - last_tx);
          end
        end
        seen_tx = 1; last_tx = cyc;
      end
    end
    n_vec++;
    if (first_rx != 4) begin
      n_err++;
      $display("FAIL int_first_rx got edge %0d want 4", first_rx);
    end
  endtask

  task automatic test_clamp();
    int unsigned n_rx, n_tx;
    for (int v = 0; v < 2; v++) begin
      bus.en = 1'b0; bus.div_load = 1'b1; bus.div_int = 16'(v); bus.div_frac = 4'd0;
      tick();
      bus.div_load = 1'b0;
      n_vec++;
      if (bus.div_ack !== 1'b1) begin
        n_err++;
        $display("FAIL clamp_ack div=%0d got %b want 1", v, bus.div_ack);
      end
      bus.en = 1'b1; n_rx = 0; n_tx = 0;
      for (int i = 0; i < 128; i++) begin
        tick();
        n_vec++;
        if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
          n_err++;
          $display("FAIL clamp_run div=%0d cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", v, cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
        end
        if (bus.rx_en === 1'b1) n_rx++;
        if (bus.tx_en === 1'b1) n_tx++;
      end
      n_vec++;
      if (n_rx != 64 || n_tx != 4) begin
        n_err++;
        $display("FAIL clamp_counts div=%0d got rx=%0d tx=%0d want rx=64 tx=4", v, n_rx, n_tx);
      end
    end
  endtask

  task automatic test_random_divisor();
    int unsigned ri, rf;
    for (int r = 0; r < 6; r++) begin
      ri = $urandom_range(2, 40);
      rf = $urandom_range(0, FRAC_N - 1);
      bus.en = 1'b0; bus.div_load = 1'b1; bus.div_int = 16'(ri); bus.div_frac = 4'(rf);
      tick();
      bus.div_load = 1'b0; bus.en = 1'b1;
      n_vec++;
      if (bus.div_ack !== 1'b1) begin
        n_err++;
        $display("FAIL rand_ack I=%0d F=%0d got %b want 1", ri, rf, bus.div_ack);
      end
      for (int i = 0; i < OS * (ri + 1) * 3 + 10; i++) begin
        tick();
        n_vec++;
        if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
          n_err++;
          $display("FAIL rand_run I=%0d F=%0d cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", ri, rf, cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
        end
      end
    end
  endtask

  task automatic test_mid_bit_load();
    int unsigned last_rx;
    bit found, acked;
    rst = 1'b1; bus.en = 1'b1; bus.div_load = 1'b0;
    tick(); tick();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL midbit_pre cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (exp_tx) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL midbit_first_tx got timeout want tx within 6000 cycles");
    end
    for (int i = 0; i < 1001; i++) begin
      if (i == 999) begin bus.div_load = 1'b1; bus.div_int = 16'd100; bus.div_frac = 4'd0; end
      if (i == 1000) bus.div_int = 16'd50;
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL midbit_load cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
    end
    bus.div_load = 1'b0;
    acked = 0;
    for (int i = 0; i < 6000 && !acked; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL midbit_wait cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (exp_ack) begin
        acked = 1;
        n_vec++;
        if (bus.tx_en !== 1'b1 || bus.div_ack !== 1'b1) begin
          n_err++;
          $display("FAIL midbit_ack_with_tx got tx=%b ack=%b want 1 1", bus.tx_en, bus.div_ack);
        end
      end
    end
    n_vec++;
    if (!acked) begin
      n_err++;
      $display("FAIL midbit_ack got timeout want ack within 6000 cycles");
    end
    last_rx = cyc;
    for (int i = 0; i < 50 * 16 * 2; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL midbit_post cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (bus.rx_en === 1'b1) begin
        n_vec++;
        if (cyc - last_rx != 50) begin
          n_err++;
          $display("FAIL midbit_rx_spacing got %0d want 50", cyc - last_rx);
        end
        last_rx = cyc;
      end
    end
  endtask

  task automatic test_enable_drop();
    int unsigned ri, rf, pre, first_rx, first_tx, eff;
    ri = $urandom_range(8, 30);
    rf = $urandom_range(0, FRAC_N - 1);
    pre = $urandom_range(50, 400);
    bus.en = 1'b0; bus.div_load = 1'b1; bus.div_int = 16'(ri); bus.div_frac = 4'(rf);
    tick();
    bus.div_load = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < pre + 20; i++) begin
      if (i == pre) bus.en = 1'b0;
      if (i == pre + 10) bus.en = 1'b1;
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL drop_around cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (i >= pre && i < pre + 10) begin
        n_vec++;
        if (bus.rx_en !== 1'b0 || bus.tx_en !== 1'b0) begin
          n_err++;
          $display("FAIL drop_quiet cyc=%0d got rx=%b tx=%b want 0 0", cyc, bus.rx_en, bus.tx_en);
        end
      end
      if (i == pre + 9) break;
    end
    bus.en = 1'b1;
    first_rx = 0; first_tx = 0;
    for (int i = 1; i <= OS * (ri + 1) * 2; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL drop_resume cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (bus.rx_en === 1'b1 && first_rx == 0) first_rx = i;
      if (bus.tx_en === 1'b1 && first_tx == 0) first_tx = i;
    end
    eff = OS * ri + ((OS - 1) * rf) / FRAC_N;
    n_vec++;
    if (first_rx != ri || first_tx != eff) begin
      n_err++;
      $display("FAIL drop_first_strobes got rx@%0d tx@%0d want rx@%0d tx@%0d", first_rx, first_tx, ri, eff);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned last_tx, n_ack;
    bit seen_tx;
    rst = 1'b1; bus.en = 1'b1; bus.div_load = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1990) begin bus.div_load = 1'b1; bus.div_int = 16'd7; bus.div_frac = 4'd3; end
      if (i == 1991) bus.div_load = 1'b0;
      if (i == 1999) rst = 1'b1;
      tick();
    end
    tick();
    n_vec++;
    if ({bus.rx_en, bus.tx_en, bus.div_ack} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_outputs got rx/tx/ack=%b%b%b want 000", bus.rx_en, bus.tx_en, bus.div_ack);
    end
    rst = 1'b0;
    seen_tx = 0; last_tx = 0; n_ack = 0;
    for (int i = 0; i < 12000; i++) begin
      tick();
      n_vec++;
      if ({bus.rx_en, bus.tx_en, bus.div_ack} !== {exp_rx, exp_tx, exp_ack}) begin
        n_err++;
        $display("FAIL rstmid_run cyc=%0d got rx/tx/ack=%b%b%b want %b%b%b", cyc, bus.rx_en, bus.tx_en, bus.div_ack, exp_rx, exp_tx, exp_ack);
      end
      if (bus.div_ack === 1'b1) n_ack++;
      if (bus.tx_en === 1'b1) begin
        if (seen_tx) begin
          n_vec++;
          if (cyc - last_tx != 5208) begin
            n_err++;
            $display("FAIL rstmid_tx_spacing got %0d want 5208", cyc - last_tx);
          end
        end
        seen_tx = 1; last_tx = cyc;
      end
    end
    n_vec++;
    if (n_ack != 0) begin
      n_err++;
      $display("FAIL rstmid_no_ack got %0d acks want 0", n_ack);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_int = '0; bus.div_frac = '0;
    m_int = DEF_I; m_frac = DEF_F; m_pend = 0; m_pint = 0; m_pfrac = 0;
    model_restart();
    #1;
    test_reset();
    test_int_enable_low();
    test_clamp();
    test_random_divisor();
    test_mid_bit_load();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
